// File: rtl/if_id_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : if_id_buf
// Purpose  : IF/ID pipeline register with a one-entry skid buffer that absorbs
//            an in-flight fetch return while decode is frozen by a stall.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_buf #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  input  logic              flush,
  input  logic              conflict_stall,
  input  logic              mem_stall,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_fire,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [PC_W-1:0]   main_pc;
  logic [INST_W-1:0] main_inst;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic [CNT_W-1:0]  cnt;

  logic adv;
  logic acc;
  logic load_main_if;
  logic load_main_skid;
  logic load_skid;
  logic cnt_inc;

  // id_valid is a pure decode of the registered state, so it is glitch-free.
  assign id_valid  = (state != ST_EMPTY);
  assign adv       = id_valid & ~conflict_stall & ~mem_stall;
  assign id_fire   = adv & ~flush;
  assign if_ready  = (state != ST_TWO);
  assign acc       = if_valid & if_ready;
  assign id_pc     = main_pc;
  assign id_inst   = main_inst;
  assign stall_cnt = cnt;
  assign cnt_inc   = id_valid & conflict_stall & ~flush & (cnt != CNT_MAX);

  always_comb begin
    state_nxt      = state;
    load_main_if   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Redirect drops everything, including whatever IF offers this cycle.
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            load_main_if = 1'b1;
            state_nxt    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (adv) begin
            if (acc) begin
              load_main_if = 1'b1;
            end else begin
              state_nxt = ST_EMPTY;
            end
          end else if (acc) begin
            load_skid = 1'b1;
            state_nxt = ST_TWO;
          end
        end
        ST_TWO: begin
          if (adv) begin
            load_main_skid = 1'b1;
            state_nxt      = ST_ONE;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_EMPTY;
      main_pc   <= '0;
      main_inst <= '0;
      skid_pc   <= '0;
      skid_inst <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_if) begin
        main_pc   <= if_pc;
        main_inst <= if_inst;
      end else if (load_main_skid) begin
        main_pc   <= skid_pc;
        main_inst <= skid_inst;
      end
      if (load_skid) begin
        skid_pc   <= if_pc;
        skid_inst <= if_inst;
      end
      if (cnt_inc) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_buf.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for if_id_buf: directed scenarios plus random traffic, checked by a
// queue-based scoreboard against an occupancy/FIFO reference model.
module tb_if_id_buf;
  localparam int PC_W    = 32;
  localparam int INST_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              resetn;
  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready;
  logic              flush;
  logic              conflict_stall;
  logic              mem_stall;
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_fire;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  if_id_buf #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .if_ready(if_ready), .flush(flush),
    .conflict_stall(conflict_stall), .mem_stall(mem_stall),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_fire(id_fire), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } item_t;

  typedef struct packed {
    logic             v;
    logic             rdy;
    logic             fire;
    logic [CNT_W-1:0] cnt;
  } st_t;

  item_t exp_q[$];
  st_t   st_q[$];
  int    errors = 0;
  int    checks = 0;
  int    occ = 0;
  int    mcnt = 0;
  bit    clear_pending = 1'b0;
  logic [PC_W-1:0] next_pc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the buffer is a FIFO of at most two accepted instructions; the head is in ID.
  task automatic cycle(input bit rn, input bit fl, input bit cs, input bit ms, input bit iv);
    st_t   s;
    item_t it;
    bit    v, rdy, fire, acc;
    @(posedge clk);
    #1;
    if (clear_pending) begin
      exp_q.delete();
      clear_pending = 1'b0;
    end
    resetn = rn; flush = fl; conflict_stall = cs; mem_stall = ms; if_valid = iv;
    if_pc = next_pc;
    if_inst = $urandom;
    v    = (occ > 0);
    rdy  = (occ < 2);
    fire = v & ~cs & ~ms & ~fl;
    s.v = v; s.rdy = rdy; s.fire = fire; s.cnt = mcnt[CNT_W-1:0];
    st_q.push_back(s);
    if (!rn) begin
      occ = 0; mcnt = 0; clear_pending = 1'b1;
    end else if (fl) begin
      occ = 0; clear_pending = 1'b1;
    end else begin
      if (v && cs && mcnt < CNT_MAX) mcnt++;
      acc = iv & rdy;
      occ = occ - (fire ? 1 : 0) + (acc ? 1 : 0);
      if (acc) begin
        it.pc = if_pc; it.inst = if_inst;
        exp_q.push_back(it);
        next_pc = next_pc + 4;
      end
    end
  endtask

  initial begin : monitor
    st_t   s;
    item_t it;
    logic [PC_W-1:0] last_pc = '0;
    bit frozen = 1'b0;
    forever begin
      @(negedge clk);
      if (st_q.size() != 0) begin
        s = st_q.pop_front();
        chk("id_valid", {63'd0, id_valid}, {63'd0, s.v});
        chk("if_ready", {63'd0, if_ready}, {63'd0, s.rdy});
        chk("id_fire", {63'd0, id_fire}, {63'd0, s.fire});
        chk("stall_cnt", {60'd0, stall_cnt}, {60'd0, s.cnt});
        if (frozen) chk("frozen_id_pc", {32'd0, id_pc}, {32'd0, last_pc});
        if (id_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL id_occupancy: id_valid=1 with pc %0h but no pending instruction", id_pc);
          end else begin
            it = exp_q[0];
            chk("id_pc", {32'd0, id_pc}, {32'd0, it.pc});
            chk("id_inst", {32'd0, id_inst}, {32'd0, it.inst});
            if (id_fire) void'(exp_q.pop_front());
          end
        end
        frozen  = id_valid & (conflict_stall | mem_stall) & ~flush & resetn;
        last_pc = id_pc;
      end
    end
  end

  initial begin : driver
    resetn = 1'b0; flush = 1'b0; conflict_stall = 1'b0; mem_stall = 1'b0;
    if_valid = 1'b0; if_pc = '0; if_inst = '0;
    repeat (2) @(posedge clk);
    // T1 stream
    cycle(1, 0, 0, 0, 0);
    next_pc = 32'h100;
    repeat (3) cycle(1, 0, 0, 0, 1);
    repeat (2) cycle(1, 0, 0, 0, 0);
    // T2 load-use with an in-flight fetch
    next_pc = 32'h100;
    repeat (2) cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 1, 0, 1);
    cycle(1, 0, 0, 0, 1);
    repeat (3) cycle(1, 0, 0, 0, 0);
    // T3 long mem_stall
    next_pc = 32'h400;
    cycle(1, 0, 0, 0, 1);
    repeat (5) cycle(1, 0, 0, 1, 1);
    repeat (3) cycle(1, 0, 0, 0, 0);
    // T4 flush while both entries are full
    next_pc = 32'h200;
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 1, 0, 1);
    next_pc = 32'h300;
    cycle(1, 1, 1, 0, 1);
    repeat (2) cycle(1, 0, 0, 0, 0);
    // T5 reset mid-stall with stall_cnt=7
    cycle(0, 0, 0, 0, 0);
    next_pc = 32'h500;
    cycle(1, 0, 0, 0, 1);
    repeat (7) cycle(1, 0, 1, 0, 1);
    cycle(0, 0, 1, 0, 1);
    repeat (2) cycle(1, 0, 0, 0, 0);
    // T6 saturation
    next_pc = 32'h600;
    cycle(1, 0, 0, 0, 1);
    repeat (20) cycle(1, 0, 1, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) != 0));
    end
    repeat (3) cycle(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("status_queue_drained", 64'(st_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
